// File: rtl/ram_if_pkg.sv
// Shared constants and state encoding for the DDR3 app-interface write path.
package ram_if_pkg;
    localparam int ADDR_WIDTH     = 27;
    localparam int APP_DATA_WIDTH = 64;
    localparam int APP_MASK_WIDTH = 8;
    localparam int WORD_WIDTH     = 16;
    localparam int BURST_WORDS    = 8;
    localparam int BEAT_WORDS     = APP_DATA_WIDTH / WORD_WIDTH;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WDATA0,
        WDATA1,
        WCMD
    } ram_writer_state_t;
endpackage

// File: rtl/ram_writer_if.sv
// MIG app-interface write bus: command channel plus write-data FIFO channel.
interface ram_writer_if #(
    parameter int ADDR_WIDTH     = ram_if_pkg::ADDR_WIDTH,
    parameter int APP_DATA_WIDTH = ram_if_pkg::APP_DATA_WIDTH,
    parameter int APP_MASK_WIDTH = ram_if_pkg::APP_MASK_WIDTH
);
    logic [ADDR_WIDTH-1:0]     ram_address;
    logic [2:0]                ram_cmd;
    logic                      ram_en;
    logic                      ram_rdy;
    logic [APP_DATA_WIDTH-1:0] ram_wdf_data;
    logic                      ram_wdf_wren;
    logic                      ram_wdf_end;
    logic [APP_MASK_WIDTH-1:0] ram_wdf_mask;
    logic                      ram_wdf_rdy;

    modport master (
        output ram_address, ram_cmd, ram_en,
        output ram_wdf_data, ram_wdf_wren, ram_wdf_end, ram_wdf_mask,
        input  ram_rdy, ram_wdf_rdy
    );

    modport slave (
        input  ram_address, ram_cmd, ram_en,
        input  ram_wdf_data, ram_wdf_wren, ram_wdf_end, ram_wdf_mask,
        output ram_rdy, ram_wdf_rdy
    );
endinterface

// File: rtl/ram_write_line_buffer.sv
// 8x16 burst line store with per-word valid; merge/clear take effect next cycle.
// Beat view (data + byte mask) is combinational from stored state, no backpressure.
module ram_write_line_buffer
    import ram_if_pkg::*;
#(
    parameter int APP_DATA_WIDTH = ram_if_pkg::APP_DATA_WIDTH,
    parameter int APP_MASK_WIDTH = ram_if_pkg::APP_MASK_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      wr,
    input  logic [2:0]                idx,
    input  logic [WORD_WIDTH-1:0]     din,
    input  logic                      beat_sel,
    output logic [BURST_WORDS-1:0]    word_vld,
    output logic [APP_DATA_WIDTH-1:0] beat_data,
    output logic [APP_MASK_WIDTH-1:0] beat_mask
);
    logic [WORD_WIDTH-1:0]  words [BURST_WORDS];
    logic [BURST_WORDS-1:0] wr_onehot;

    assign wr_onehot = wr ? (BURST_WORDS'(1) << idx) : '0;

    // Clear and write in the same cycle leaves only the new word valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_vld <= '0;
            for (int i = 0; i < BURST_WORDS; i++) begin
                words[i] <= '0;
            end
        end else begin
            word_vld <= (clr ? '0 : word_vld) | wr_onehot;
            if (wr) begin
                words[idx] <= din;
            end
        end
    end

    always_comb begin
        beat_data = '0;
        beat_mask = '1;
        for (int k = 0; k < BEAT_WORDS; k++) begin
            if (word_vld[{beat_sel, 2'(k)}]) begin
                beat_data[WORD_WIDTH*k +: WORD_WIDTH] = words[{beat_sel, 2'(k)}];
                beat_mask[2*k +: 2]                   = 2'b00;
            end
        end
    end
endmodule

// File: rtl/ram_writer.sv
// Coalesces 16-bit word writes into masked BL8 MIG writes; RAM_WRITER_TIMEOUT_EN adds idle auto-flush.
// Accept->wdf_wren 1 cycle min, 3 cycles per burst; write_ready drops while a line drains, ram_* hold on stall.
module ram_writer
    import ram_if_pkg::*;
#(
    parameter int ADDR_WIDTH     = ram_if_pkg::ADDR_WIDTH,
    parameter int APP_DATA_WIDTH = ram_if_pkg::APP_DATA_WIDTH,
    parameter int APP_MASK_WIDTH = ram_if_pkg::APP_MASK_WIDTH,
    parameter int FLUSH_TIMEOUT  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [15:0]           write_data,
    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic [15:0]           lines_written,
    ram_writer_if.master          ram
);
    ram_writer_state_t state;

    logic [ADDR_WIDTH-4:0]     base_line;
    logic                      hold_vld;
    logic [ADDR_WIDTH-1:0]     hold_addr;
    logic [15:0]               hold_data;
    logic                      wren_q;
    logic                      end_q;
    logic                      en_q;
    logic [ADDR_WIDTH-1:0]     cmd_addr;

    logic                      accept;
    logic                      same_base;
    logic                      line_full;
    logic                      flush_now;
    logic                      lb_clr;
    logic                      lb_wr;
    logic [2:0]                lb_idx;
    logic [15:0]               lb_din;
    logic [BURST_WORDS-1:0]    word_vld;
    logic [APP_DATA_WIDTH-1:0] beat_data;
    logic [APP_MASK_WIDTH-1:0] beat_mask;

    assign accept    = write_valid & write_ready;
    assign same_base = (write_address[ADDR_WIDTH-1:3] == base_line);
    // Fullness includes a word merged this cycle so a completing write drains immediately.
    assign line_full = &(word_vld | ((accept && same_base) ? (8'd1 << write_address[2:0]) : 8'd0));

`ifdef RAM_WRITER_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != FILL || accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign flush_now = flush | (idle_cnt == 16'(FLUSH_TIMEOUT));
`else
    logic unused_flush_timeout;
    assign unused_flush_timeout = ^FLUSH_TIMEOUT;
    assign flush_now            = flush;
`endif

    always_comb begin
        lb_clr = 1'b0;
        lb_wr  = 1'b0;
        lb_idx = write_address[2:0];
        lb_din = write_data;
        case (state)
            IDLE: lb_wr = accept;
            FILL: lb_wr = accept & same_base;
            WCMD: begin
                if (ram.ram_rdy) begin
                    lb_clr = 1'b1;
                    lb_wr  = hold_vld;
                    lb_idx = hold_addr[2:0];
                    lb_din = hold_data;
                end
            end
            default: ;
        endcase
    end

    ram_write_line_buffer #(
        .APP_DATA_WIDTH (APP_DATA_WIDTH),
        .APP_MASK_WIDTH (APP_MASK_WIDTH)
    ) u_line (
        .clk       (clk),
        .reset     (reset),
        .clr       (lb_clr),
        .wr        (lb_wr),
        .idx       (lb_idx),
        .din       (lb_din),
        .beat_sel  (end_q),
        .word_vld  (word_vld),
        .beat_data (beat_data),
        .beat_mask (beat_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            write_ready   <= 1'b0;
            busy          <= 1'b0;
            lines_written <= '0;
            base_line     <= '0;
            hold_vld      <= 1'b0;
            hold_addr     <= '0;
            hold_data     <= '0;
            wren_q        <= 1'b0;
            end_q         <= 1'b0;
            en_q          <= 1'b0;
            cmd_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_ready <= 1'b1;
                    if (accept) begin
                        base_line <= write_address[ADDR_WIDTH-1:3];
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (accept && !same_base) begin
                        hold_vld  <= 1'b1;
                        hold_addr <= write_address;
                        hold_data <= write_data;
                    end
                    if ((accept && !same_base) || line_full || flush_now) begin
                        write_ready <= 1'b0;
                        wren_q      <= 1'b1;
                        end_q       <= 1'b0;
                        state       <= WDATA0;
                    end
                end
                WDATA0: begin
                    if (ram.ram_wdf_rdy) begin
                        end_q <= 1'b1;
                        state <= WDATA1;
                    end
                end
                WDATA1: begin
                    if (ram.ram_wdf_rdy) begin
                        wren_q   <= 1'b0;
                        end_q    <= 1'b0;
                        en_q     <= 1'b1;
                        cmd_addr <= {base_line, 3'b000};
                        state    <= WCMD;
                    end
                end
                WCMD: begin
                    if (ram.ram_rdy) begin
                        en_q          <= 1'b0;
                        cmd_addr      <= '0;
                        lines_written <= lines_written + 16'd1;
                        write_ready   <= 1'b1;
                        if (hold_vld) begin
                            base_line <= hold_addr[ADDR_WIDTH-1:3];
                            hold_vld  <= 1'b0;
                            state     <= FILL;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram.ram_en       = en_q;
    assign ram.ram_cmd      = CMD_WRITE;
    assign ram.ram_address  = cmd_addr;
    assign ram.ram_wdf_wren = wren_q;
    assign ram.ram_wdf_end  = end_q;
    assign ram.ram_wdf_data = wren_q ? beat_data : '0;
    assign ram.ram_wdf_mask = wren_q ? beat_mask : '0;
endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer: coalescing, masks, holding register, stalls, async reset.
module tb_ram_writer;
    import ram_if_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [15:0]           write_data;
    logic                  write_valid;
    logic                  write_ready;
    logic                  flush;
    logic                  busy;
    logic [15:0]           lines_written;

    int total = 0;
    int bad   = 0;
    int cmd_count = 0;
    int cmd_base  = 0;

    ram_writer_if ram_bus ();

    ram_writer dut (
        .clk           (clk),
        .reset         (reset),
        .write_address (write_address),
        .write_data    (write_data),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .flush         (flush),
        .busy          (busy),
        .lines_written (lines_written),
        .ram           (ram_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && ram_bus.ram_en && ram_bus.ram_rdy) cmd_count++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [ADDR_WIDTH-1:0] a, input logic [15:0] d);
        write_address = a;
        write_data    = d;
        write_valid   = 1'b1;
        for (int i = 0; i < 50 && write_ready !== 1'b1; i++) cyc();
        chk("wr_ready_seen", 64'(write_ready), 64'd1);
        cyc();
        write_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic e, input logic [63:0] d, input logic [7:0] m);
        chk({tag, "_wren"}, 64'(ram_bus.ram_wdf_wren), 64'd1);
        chk({tag, "_end"},  64'(ram_bus.ram_wdf_end), 64'(e));
        chk({tag, "_data"}, ram_bus.ram_wdf_data, d);
        chk({tag, "_mask"}, 64'(ram_bus.ram_wdf_mask), 64'(m));
    endtask

    task automatic chk_cmd(input string tag, input logic [ADDR_WIDTH-1:0] a);
        chk({tag, "_en"},   64'(ram_bus.ram_en), 64'd1);
        chk({tag, "_addr"}, 64'(ram_bus.ram_address), 64'(a));
        chk({tag, "_cmd"},  64'(ram_bus.ram_cmd), 64'(CMD_WRITE));
        chk({tag, "_wren"}, 64'(ram_bus.ram_wdf_wren), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(write_ready), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_lines"}, 64'(lines_written), 64'd0);
        chk({tag, "_wren"},  64'(ram_bus.ram_wdf_wren), 64'd0);
        chk({tag, "_end"},   64'(ram_bus.ram_wdf_end), 64'd0);
        chk({tag, "_data"},  ram_bus.ram_wdf_data, 64'd0);
        chk({tag, "_mask"},  64'(ram_bus.ram_wdf_mask), 64'd0);
        chk({tag, "_en"},    64'(ram_bus.ram_en), 64'd0);
        chk({tag, "_addr"},  64'(ram_bus.ram_address), 64'd0);
        chk({tag, "_cmd"},   64'(ram_bus.ram_cmd), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset               = 1'b1;
        write_address       = '0;
        write_data          = '0;
        write_valid         = 1'b0;
        flush               = 1'b0;
        ram_bus.ram_rdy     = 1'b1;
        ram_bus.ram_wdf_rdy = 1'b1;
        #12;
        chk_all_zero("rst");
        cyc();
        reset = 1'b0;
        chk("ready_before_edge", 64'(write_ready), 64'd0);
        cyc();
        chk("ready_after_edge", 64'(write_ready), 64'd1);

        // Full line 0x10..0x17 drains on its own.
        for (int i = 0; i < 8; i++) write_word(27'h10 + 27'(i), 16'h1000 + 16'(i));
        chk_beat("full_b0", 1'b0, 64'h1003_1002_1001_1000, 8'h00);
        chk("full_ready_low", 64'(write_ready), 64'd0);
        cyc();
        chk_beat("full_b1", 1'b1, 64'h1007_1006_1005_1004, 8'h00);
        cyc();
        chk_cmd("full_cmd", 27'h10);
        cyc();
        chk("full_lines", 64'(lines_written), 64'd1);
        chk("full_en_off", 64'(ram_bus.ram_en), 64'd0);
        chk("full_idle_busy", 64'(busy), 64'd0);

        // Single word in upper beat, flushed.
        write_word(27'h25, 16'hBEEF);
        chk("part_busy", 64'(busy), 64'd1);
        chk("part_no_drain", 64'(ram_bus.ram_wdf_wren), 64'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_beat("part_b0", 1'b0, 64'h0, 8'hFF);
        cyc();
        chk_beat("part_b1", 1'b1, 64'h0000_0000_BEEF_0000, 8'hF3);
        cyc();
        chk_cmd("part_cmd", 27'h20);
        cyc();
        chk("part_lines", 64'(lines_written), 64'd2);

        // Different base parks in the holding register.
        write_word(27'h08, 16'hAAAA);
        write_word(27'h40, 16'h5555);
        chk("hold_ready_low", 64'(write_ready), 64'd0);
        chk_beat("hold_b0", 1'b0, 64'h0000_0000_0000_AAAA, 8'hFC);
        cyc();
        chk_beat("hold_b1", 1'b1, 64'h0, 8'hFF);
        chk("hold_ready_low2", 64'(write_ready), 64'd0);
        cyc();
        chk_cmd("hold_cmd", 27'h08);
        chk("hold_ready_low3", 64'(write_ready), 64'd0);
        cyc();
        chk("hold_lines", 64'(lines_written), 64'd3);
        chk("hold_ready_back", 64'(write_ready), 64'd1);
        chk("hold_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_beat("hold2_b0", 1'b0, 64'h0000_0000_0000_5555, 8'hFC);
        cyc();
        cyc();
        chk_cmd("hold2_cmd", 27'h40);
        cyc();
        chk("hold2_lines", 64'(lines_written), 64'd4);
        chk("hold2_busy", 64'(busy), 64'd0);

        // Repeat index: last write wins.
        write_word(27'h03, 16'h1111);
        write_word(27'h03, 16'h2222);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_beat("rep_b0", 1'b0, 64'h2222_0000_0000_0000, 8'h3F);
        cyc();
        chk_beat("rep_b1", 1'b1, 64'h0, 8'hFF);
        cyc();
        chk_cmd("rep_cmd", 27'h00);
        cyc();
        chk("rep_lines", 64'(lines_written), 64'd5);

        // Stalls on both MIG channels.
        write_word(27'h0A, 16'h7777);
        ram_bus.ram_wdf_rdy = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_beat("stall_b0", 1'b0, 64'h0000_7777_0000_0000, 8'hCF);
            cyc();
        end
        chk_beat("stall_b0_end", 1'b0, 64'h0000_7777_0000_0000, 8'hCF);
        ram_bus.ram_wdf_rdy = 1'b1;
        ram_bus.ram_rdy     = 1'b0;
        cmd_base            = cmd_count;
        cyc();
        chk_beat("stall_b1", 1'b1, 64'h0, 8'hFF);
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk_cmd("stall_cmd", 27'h08);
            chk("stall_lines", 64'(lines_written), 64'd5);
            cyc();
        end
        ram_bus.ram_rdy = 1'b1;
        cyc();
        chk("stall_en_off", 64'(ram_bus.ram_en), 64'd0);
        chk("stall_lines_done", 64'(lines_written), 64'd6);
        chk("stall_one_cmd", 64'(cmd_count - cmd_base), 64'd1);

        // Reset during WDATA1.
        write_word(27'h31, 16'h4321);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("mid_end", 64'(ram_bus.ram_wdf_end), 64'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        cyc();
        reset = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_lines", 64'(lines_written), 64'd0);
        cyc();
        write_word(27'h00, 16'hCAFE);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_beat("post_b0", 1'b0, 64'h0000_0000_0000_CAFE, 8'hFC);
        cyc();
        chk_beat("post_b1", 1'b1, 64'h0, 8'hFF);
        cyc();
        chk_cmd("post_cmd", 27'h00);
        cyc();
        chk("post_lines", 64'(lines_written), 64'd1);
        chk("post_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
